// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer.
//   S_IDLE/S_SHIFT/S_PAR/S_GAP : FSM state encodings (2 bits)
//   GAP_CNT_W                  : width of the inter-frame gap counter
package ser_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_PAR   = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam int GAP_CNT_W = 4;

endpackage : ser_pkg

// File: rtl/ser_shift_reg.sv
// Parallel-load, MSB-first shift register for the bit serializer.
// Optional feature macro: SER_PARITY_EN (adds a registered even-parity bit of
// the loaded word).
// Ports:
//   clk      in   clock, all updates on posedge
//   rst      in   synchronous active-high reset
//   load_i   in   capture data_i (takes priority over shift_i)
//   shift_i  in   shift left by one, zero fill
//   data_i   in   WIDTH-bit word to capture
//   msb_o    out  current MSB (the bit being emitted)
//   parity_o out  even parity of the captured word (SER_PARITY_EN only)
module ser_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
`ifdef SER_PARITY_EN
    ,
    output logic             parity_o
`endif
);

    logic [WIDTH-1:0] shreg_q;

    // Shift register: load a new word or shift it out MSB-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shreg_q <= shreg_q;
        end
    end

    assign msb_o = shreg_q[WIDTH-1];

`ifdef SER_PARITY_EN
    logic par_q;

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    // Parity is captured with the word, since the word is destroyed by shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (load_i) begin
            par_q <= even_parity(data_i);
        end else begin
            par_q <= par_q;
        end
    end

    assign parity_o = par_q;
`endif

endmodule : ser_shift_reg

// File: rtl/bit_serializer.sv
// Bit serializer: accepts parallel words over valid/ready and emits them
// MSB-first, one bit per clock, on x/x_valid for a downstream sequence FSM.
// Optional feature macro: SER_PARITY_EN (one extra even-parity bit per frame).
// Parameters: WIDTH data bits per word (>=2), GAP idle cycles after each frame (0..15).
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   din        in   parallel word
//   din_valid  in   din holds a word to send
//   din_ready  out  word can be accepted this cycle (IDLE and not in reset)
//   x          out  serial bit
//   x_valid    out  x carries a frame bit
//   busy       out  frame or gap in progress
//   frame_done out  pulse on the last bit of a frame
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD  = GAP_CNT_W'((GAP > 0) ? (GAP - 1) : 0);
    // Where the FSM goes once every bit of the frame has been emitted.
    localparam logic [1:0]           END_STATE = (GAP > 0) ? S_GAP : S_IDLE;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GAP_CNT_W-1:0] gap_q, gap_d;
    logic                 accept_s;
    logic                 shift_s;
    logic                 msb_s;

    assign din_ready = (state_q == S_IDLE) && !rst;
    assign accept_s  = din_valid && din_ready;
    assign shift_s   = (state_q == S_SHIFT);
    assign busy      = (state_q != S_IDLE);

`ifdef SER_PARITY_EN
    logic par_s;

    ser_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept_s),
        .shift_i  (shift_s),
        .data_i   (din),
        .msb_o    (msb_s),
        .parity_o (par_s)
    );
`else
    ser_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept_s),
        .shift_i  (shift_s),
        .data_i   (din),
        .msb_o    (msb_s)
    );
`endif

    // Next-state logic for the FSM, bit counter and gap counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_SHIFT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
`ifdef SER_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = END_STATE;
                    gap_d   = GAP_LOAD;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PAR: begin
`ifdef SER_PARITY_EN
                state_d = END_STATE;
                gap_d   = GAP_LOAD;
`else
                state_d = S_IDLE;
`endif
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    // Output decode from registered state only (no path from din/din_valid).
    always_comb begin
        x          = 1'b0;
        x_valid    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_SHIFT: begin
                x       = msb_s;
                x_valid = 1'b1;
`ifdef SER_PARITY_EN
                frame_done = 1'b0;
`else
                frame_done = (cnt_q == '0);
`endif
            end
            S_PAR: begin
`ifdef SER_PARITY_EN
                x          = par_s;
                x_valid    = 1'b1;
                frame_done = 1'b1;
`else
                x          = 1'b0;
                x_valid    = 1'b0;
                frame_done = 1'b0;
`endif
            end
            default: begin
                x          = 1'b0;
                x_valid    = 1'b0;
                frame_done = 1'b0;
            end
        endcase
    end

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer (WIDTH=4): two instances share the inputs, one with
// GAP=0 and one with GAP=2. The reference model is a per-instance timeline
// queue of expected output cycles built from each accepted word.
module tb_bit_serializer;

    localparam int W = 4;
`ifdef SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    // Entry layout: {ready, busy, frame_done, x_valid, x}
    typedef logic [4:0] ent_t;
    typedef ent_t ent_q_t[$];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic [1:0]   rdy, xo, xv, bsy, fd;

    int n_cmp = 0;
    int n_err = 0;
    ent_q_t q0, q1;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy[0]), .x(xo[0]), .x_valid(xv[0]), .busy(bsy[0]),
        .frame_done(fd[0])
    );

    bit_serializer #(.WIDTH(W), .GAP(2)) dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy[1]), .x(xo[1]), .x_valid(xv[1]), .busy(bsy[1]),
        .frame_done(fd[1])
    );

    // Expected cycles for one accepted word: data bits MSB-first, optional
    // parity bit, then gap cycles; din_ready is low throughout.
    function automatic ent_q_t frame(input logic [W-1:0] w, input int gap);
        ent_q_t f;
        f = {};
        for (int i = W - 1; i >= 0; i--) begin
            f.push_back({1'b0, 1'b1, (i == 0) && !PAR, 1'b1, w[i]});
        end
        if (PAR) begin
            f.push_back({1'b0, 1'b1, 1'b1, 1'b1, 1'b0 ^ logic'($countones(w) % 2)});
        end
        for (int i = 0; i < gap; i++) begin
            f.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        return f;
    endfunction

    // Advance both models by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        if (rst) begin
            q0 = {};
            q1 = {};
        end else begin
            if (q0.size() == 0) begin
                if (din_valid) q0 = frame(din, 0);
            end else begin
                void'(q0.pop_front());
            end
            if (q1.size() == 0) begin
                if (din_valid) q1 = frame(din, 2);
            end else begin
                void'(q1.pop_front());
            end
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_unit(input int u, input string step);
        ent_t e;
        int   sz;
        sz = (u == 0) ? q0.size() : q1.size();
        if (sz == 0) e = {!rst, 1'b0, 1'b0, 1'b0, 1'b0};
        else         e = (u == 0) ? q0[0] : q1[0];
        chk($sformatf("%s.u%0d.din_ready", step, u), rdy[u], e[4]);
        chk($sformatf("%s.u%0d.busy", step, u), bsy[u], e[3]);
        chk($sformatf("%s.u%0d.frame_done", step, u), fd[u], e[2]);
        chk($sformatf("%s.u%0d.x_valid", step, u), xv[u], e[1]);
        chk($sformatf("%s.u%0d.x", step, u), xo[u], e[0]);
    endtask

    // One clock: update the model at the edge, then sample #1 later.
    task automatic tick(input string step);
        @(posedge clk);
        model_edge();
        #1;
        check_unit(0, step);
        check_unit(1, step);
    endtask

    task automatic ticks(input int n, input string step);
        for (int i = 0; i < n; i++) tick(step);
    endtask

    initial begin
        // 1: reset for two cycles, then release
        rst = 1'b1;
        din_valid = 1'b0;
        ticks(2, "reset");
        rst = 1'b0;
        #1;
        check_unit(0, "release");
        check_unit(1, "release");
        tick("idle");

        // 2/3: single word 1011, then 1001
        din = 4'b1011;
        din_valid = 1'b1;
        tick("w1011");
        din_valid = 1'b0;
        din = 4'b0000;
        ticks(8, "w1011");
        din = 4'b1001;
        din_valid = 1'b1;
        tick("w1001");
        din_valid = 1'b0;
        ticks(8, "w1001");

        // 4: din_valid held high, words A then 5
        din = 4'hA;
        din_valid = 1'b1;
        tick("backA");
        ticks(3, "backA");
        din = 4'h5;
        ticks(12, "back5");
        din_valid = 1'b0;
        ticks(8, "backdrain");

        // 5: din_valid pulsed mid-frame with F is ignored
        din = 4'h6;
        din_valid = 1'b1;
        tick("w6");
        din_valid = 1'b0;
        tick("w6");
        din = 4'hF;
        din_valid = 1'b1;
        tick("ignF");
        din_valid = 1'b0;
        din = 4'h0;
        ticks(8, "w6tail");

        // 6: reset on the 2nd bit of 1100, then word 3
        din = 4'b1100;
        din_valid = 1'b1;
        tick("w1100");
        din_valid = 1'b0;
        tick("w1100");
        rst = 1'b1;
        tick("midrst");
        rst = 1'b0;
        din = 4'h3;
        din_valid = 1'b1;
        tick("w3");
        din_valid = 1'b0;
        ticks(8, "w3");

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            din       = W'($urandom_range(0, 15));
            din_valid = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 59) == 0);
            tick("rand");
        end
        rst = 1'b0;
        din_valid = 1'b0;
        ticks(10, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bit_serializer
